control_unit: RTL

Multi-cycle instruction sequencer that drives the datapath's control inputs (ra_addr, rb_addr, write_addr, write_en, write_alu, is_load, imm_flag, imm_data, alu_opcode) and consumes its status outputs (alu_zero, alu_carry).
Owns the program counter, instruction register, latched flags and the data-RAM strobes.
Sits between the synchronous instruction ROM / data RAM and the datapath at the core top level.

---
 rtl/control_unit_pkg.sv | 63 ++++++
 rtl/control_unit_decode.sv | 50 +++++
 rtl/control_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/control_unit_pkg.sv
// Shared definitions for the control unit: ALU and instruction opcodes, FSM states,
// instruction field positions and the decoded-instruction record.
package control_unit_pkg;

   localparam int unsigned InstrW = 16;

   // Instruction field positions
   localparam int unsigned OpLsb  = 12;
   localparam int unsigned RdLsb  = 8;
   localparam int unsigned RaLsb  = 4;
   localparam int unsigned RbLsb  = 0;
   localparam int unsigned ImmLsb = 0;

   localparam logic [2:0] AluAdd = 3'b000;
   localparam logic [2:0] AluSub = 3'b001;
   localparam logic [2:0] AluAnd = 3'b010;
   localparam logic [2:0] AluOr  = 3'b011;
   localparam logic [2:0] AluXor = 3'b100;
   localparam logic [2:0] AluNot = 3'b101;
   localparam logic [2:0] AluShl = 3'b110;
   localparam logic [2:0] AluShr = 3'b111;

   localparam logic [3:0] OpAddi = 4'h8;
   localparam logic [3:0] OpLd   = 4'h9;
   localparam logic [3:0] OpSt   = 4'hA;
   localparam logic [3:0] OpNop  = 4'hB;
   localparam logic [3:0] OpJmp  = 4'hC;
   localparam logic [3:0] OpBz   = 4'hD;
   localparam logic [3:0] OpBc   = 4'hE;
   localparam logic [3:0] OpHlt  = 4'hF;

   typedef enum logic [2:0] {
      StFetch,
      StDecode,
      StExec,
      StMem,
      StWb,
      StHalt
   } state_e;

   typedef enum logic [3:0] {
      ClsAlu,
      ClsImm,
      ClsLd,
      ClsSt,
      ClsJmp,
      ClsBz,
      ClsBc,
      ClsNop,
      ClsHlt
   } cls_e;

   typedef struct packed {
      cls_e       cls;
      logic [2:0] alu_opcode;
      logic [3:0] rd;
      logic [3:0] ra;
      logic [3:0] rb;
      logic [7:0] imm;
      state_e     next_state;
   } decode_t;

endpackage

// File: rtl/control_unit_decode.sv
// Combinational instruction decode: class, ALU opcode, register fields and DECODE successor.
// CU_CARRY_BRANCH_EN enables opcode 1110 as BC; otherwise it decodes as NOP.
module control_unit_decode
   import control_unit_pkg::*;
(
   input  logic [InstrW-1:0] instr,
   output decode_t           dec
);

   logic [3:0] op;
   cls_e       cls;

   assign op = instr[OpLsb +: 4];

   always_comb begin
      cls = ClsNop;
      if (!op[3]) begin
         cls = ClsAlu;
      end else begin
         case (op)
            OpAddi:  cls = ClsImm;
            OpLd:    cls = ClsLd;
            OpSt:    cls = ClsSt;
            OpJmp:   cls = ClsJmp;
            OpBz:    cls = ClsBz;
`ifdef CU_CARRY_BRANCH_EN
            OpBc:    cls = ClsBc;
`endif
            OpHlt:   cls = ClsHlt;
            default: cls = ClsNop;
         endcase
      end
   end

   always_comb begin
      dec.cls        = cls;
      dec.rd         = instr[RdLsb +: 4];
      dec.ra         = instr[RaLsb +: 4];
      dec.rb         = instr[RbLsb +: 4];
      dec.imm        = instr[ImmLsb +: 8];
      dec.alu_opcode = (cls == ClsAlu) ? op[2:0] : AluAdd;
      case (cls)
         ClsAlu, ClsImm, ClsJmp, ClsBz, ClsBc: dec.next_state = StExec;
         ClsLd, ClsSt:                         dec.next_state = StMem;
         ClsHlt:                               dec.next_state = StHalt;
         default:                              dec.next_state = StFetch;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer: owns pc, IR and Z/C flags and drives datapath and data-RAM controls.
module control_unit
   import control_unit_pkg::*;
#(
   parameter int unsigned PC_W    = 8,
   parameter int unsigned INSTR_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   output logic [PC_W-1:0]    instr_addr,
   input  logic [INSTR_W-1:0] instr_data,
   output logic [7:0]         ram_addr,
   output logic               ram_we,
   input  logic               alu_zero,
   input  logic               alu_carry,
   output logic [2:0]         alu_opcode,
   output logic [3:0]         ra_addr,
   output logic [3:0]         rb_addr,
   output logic [3:0]         write_addr,
   output logic               write_en,
   output logic               write_alu,
   output logic               is_load,
   output logic               imm_flag,
   output logic [7:0]         imm_data,
   output logic               halted
);

   state_e             state_q, state_d;
   logic [PC_W-1:0]    pc_q;
   logic [INSTR_W-1:0] ir_q;
   logic               z_q, c_q;
   logic [InstrW-1:0]  dec_instr;
   decode_t            dec;
   logic               take_branch;

   // In DECODE the IR is not loaded yet, so the successor state comes from the ROM word.
   assign dec_instr = (state_q == StDecode) ? instr_data : ir_q;

   control_unit_decode u_decode (
      .instr (dec_instr),
      .dec   (dec)
   );

   assign take_branch = (dec.cls == ClsJmp)
                      || ((dec.cls == ClsBz) && z_q)
                      || ((dec.cls == ClsBc) && c_q);

   assign instr_addr = pc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= '0;
         ir_q <= '0;
         z_q  <= 1'b0;
         c_q  <= 1'b0;
      end else begin
         if (state_q == StDecode) begin
            ir_q <= instr_data;
            pc_q <= pc_q + PC_W'(1);
         end
         if (state_q == StExec) begin
            if ((dec.cls == ClsAlu) || (dec.cls == ClsImm)) begin
               z_q <= alu_zero;
               c_q <= alu_carry;
            end
            if (take_branch) begin
               pc_q <= PC_W'(dec.imm);
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StFetch:  state_d = StDecode;
         StDecode: state_d = dec.next_state;
         StExec:   state_d = StFetch;
         StMem:    state_d = (dec.cls == ClsSt) ? StFetch : StWb;
         StWb:     state_d = StFetch;
         StHalt:   state_d = StHalt;
         default:  state_d = StFetch;
      endcase
   end

   always_comb begin
      ram_addr   = '0;
      ram_we     = 1'b0;
      alu_opcode = '0;
      ra_addr    = '0;
      rb_addr    = '0;
      write_addr = '0;
      write_en   = 1'b0;
      write_alu  = 1'b0;
      is_load    = 1'b0;
      imm_flag   = 1'b0;
      imm_data   = '0;
      halted     = 1'b0;
      if (state_q != StFetch) begin
         // ADDI and ST both source register A from the rd field.
         ra_addr    = ((dec.cls == ClsImm) || (dec.cls == ClsSt)) ? dec.rd : dec.ra;
         rb_addr    = dec.rb;
         write_addr = dec.rd;
         imm_data   = dec.imm;
         alu_opcode = dec.alu_opcode;
      end
      case (state_q)
         StExec: begin
            if ((dec.cls == ClsAlu) || (dec.cls == ClsImm)) begin
               write_en  = 1'b1;
               write_alu = 1'b1;
               imm_flag  = (dec.cls == ClsImm);
            end
         end
         StMem: begin
            ram_addr = dec.imm;
            ram_we   = (dec.cls == ClsSt);
         end
         StWb: begin
            ram_addr = dec.imm;
            write_en = 1'b1;
            is_load  = 1'b1;
         end
         StHalt:  halted = 1'b1;
         default: ;
      endcase
   end

endmodule
